// File: rtl/clkdiv_monitor.sv
// -----------------------------------------------------------------------------
// clkdiv_monitor
//   Checks the output of a synchronous mod-N clock divider. The divided signal
//   is sampled directly on the source clock, because the divider output is a
//   register on that same clock.
//   The block measures the period and the high time of the divided signal. It
//   flags any deviation from the expected values, reports a missing edge, and
//   maintains a lock indication.
//
// Optional feature: define CLKMON_STICKY_EN to add a sticky error flag
//   (err_sticky) with a clear input (err_clr). A set wins over a clear that
//   arrives in the same cycle.
//
// Ports:
//   clk          source clock (the clock that also drives the divider)
//   rst_n        asynchronous active-low reset
//   div_clk_in   divider output under test
//   err_clr      clear for err_sticky (CLKMON_STICKY_EN only)
//   err_sticky   latched error flag (CLKMON_STICKY_EN only)
//   edge_pulse   one-cycle pulse for each detected rising edge
//   period_meas  last captured period, in clk cycles
//   high_meas    last captured high time, in clk cycles
//   period_err   one-cycle pulse when a captured period is not EXP_PERIOD
//   high_err     one-cycle pulse when a captured high time is not EXP_HIGH
//   stuck_err    one-cycle pulse when no rising edge arrives within TIMEOUT
//   locked       set after LOCK_COUNT consecutive good periods
// -----------------------------------------------------------------------------
module clkdiv_monitor #(
  parameter int unsigned EXP_PERIOD = 6,
  parameter int unsigned EXP_HIGH   = 2,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_clk_in,
`ifdef CLKMON_STICKY_EN
  input  logic             err_clr,
  output logic             err_sticky,
`endif
  output logic             edge_pulse,
  output logic [CNT_W-1:0] period_meas,
  output logic [CNT_W-1:0] high_meas,
  output logic             period_err,
  output logic             high_err,
  output logic             stuck_err,
  output logic             locked
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  EXP_PER_C = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0]  EXP_HI_C  = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    MEASURE = 2'd1,
    TRACK   = 2'd2
  } state_t;

  state_t              state_r;
  logic                d_q_r;
  logic [CNT_W-1:0]    per_cnt_r;
  logic [CNT_W-1:0]    high_cnt_r;
  logic [GOOD_W-1:0]   good_cnt_r;
  logic [GOOD_W-1:0]   good_nxt_s;
  logic                rise_s;
  logic                fall_s;
  logic                per_ok_s;
  logic                high_ok_s;
  logic                timeout_s;

  assign rise_s    = div_clk_in & ~d_q_r;
  assign fall_s    = ~div_clk_in & d_q_r;
  assign per_ok_s  = (per_cnt_r == EXP_PER_C);
  assign high_ok_s = (high_cnt_r == EXP_HI_C);
  // A rise arriving in the same cycle as the timeout takes priority over it.
  assign timeout_s = (state_r != ACQUIRE) && !rise_s && (per_cnt_r == TIMEOUT_C);

  // Edge-detect delay register and the saturating period/high-time counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q_r      <= 1'b0;
      per_cnt_r  <= {CNT_W{1'b0}};
      high_cnt_r <= {CNT_W{1'b0}};
    end else begin
      d_q_r <= div_clk_in;
      if (rise_s) begin
        per_cnt_r  <= CNT_W'(1);
        high_cnt_r <= CNT_W'(1);
      end else begin
        per_cnt_r <= (per_cnt_r == CNT_MAX) ? per_cnt_r : per_cnt_r + CNT_W'(1);
        if (div_clk_in && (high_cnt_r != CNT_MAX)) begin
          high_cnt_r <= high_cnt_r + CNT_W'(1);
        end else begin
          high_cnt_r <= high_cnt_r;
        end
      end
    end
  end

  // Next value of the good-period run length. Any error clears the run.
  always_comb begin
    good_nxt_s = good_cnt_r;
    if (state_r == ACQUIRE) begin
      good_nxt_s = {GOOD_W{1'b0}};
    end else if (timeout_s) begin
      good_nxt_s = {GOOD_W{1'b0}};
    end else if (fall_s && !high_ok_s) begin
      good_nxt_s = {GOOD_W{1'b0}};
    end else if (rise_s) begin
      if (!per_ok_s) begin
        good_nxt_s = {GOOD_W{1'b0}};
      end else if (good_cnt_r == LOCK_C) begin
        good_nxt_s = good_cnt_r;
      end else begin
        good_nxt_s = good_cnt_r + GOOD_W'(1);
      end
    end else begin
      good_nxt_s = good_cnt_r;
    end
  end

  // Monitor state machine with registered captures, pulses and lock status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ACQUIRE;
      good_cnt_r  <= {GOOD_W{1'b0}};
      edge_pulse  <= 1'b0;
      period_meas <= {CNT_W{1'b0}};
      high_meas   <= {CNT_W{1'b0}};
      period_err  <= 1'b0;
      high_err    <= 1'b0;
      stuck_err   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      edge_pulse <= rise_s;
      period_err <= 1'b0;
      high_err   <= 1'b0;
      stuck_err  <= timeout_s;
      good_cnt_r <= good_nxt_s;
      locked     <= (good_nxt_s == LOCK_C);
      case (state_r)
        ACQUIRE: begin
          // Falls are ignored here. The first rise only starts a measurement.
          if (rise_s) begin
            state_r <= MEASURE;
          end
        end
        MEASURE, TRACK: begin
          if (fall_s) begin
            high_meas <= high_cnt_r;
            high_err  <= !high_ok_s;
          end
          if (rise_s) begin
            period_meas <= per_cnt_r;
            period_err  <= !per_ok_s;
            state_r     <= TRACK;
          end else if (timeout_s) begin
            state_r <= ACQUIRE;
          end
        end
        default: begin
          state_r <= ACQUIRE;
        end
      endcase
    end
  end

`ifdef CLKMON_STICKY_EN
  // Sticky error flag. It is set by any error pulse, and the set beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (period_err || high_err || stuck_err) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_clkdiv_monitor.sv
module tb_clkdiv_monitor;

  localparam int EXP_PERIOD = 6;
  localparam int EXP_HIGH   = 2;
  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 24;

  logic       clk;
  logic       rst_n;
  logic       div_clk_in;
  logic       edge_pulse;
  logic [7:0] period_meas;
  logic [7:0] high_meas;
  logic       period_err;
  logic       high_err;
  logic       stuck_err;
  logic       locked;
`ifdef CLKMON_STICKY_EN
  logic       err_clr;
  logic       err_sticky;
`endif

  clkdiv_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_clk_in (div_clk_in),
`ifdef CLKMON_STICKY_EN
    .err_clr    (err_clr),
    .err_sticky (err_sticky),
`endif
    .edge_pulse (edge_pulse),
    .period_meas(period_meas),
    .high_meas  (high_meas),
    .period_err (period_err),
    .high_err   (high_err),
    .stuck_err  (stuck_err),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;
  int cyc;

  // Stimulus: value of div_clk_in (and err_clr) for each cycle.
  int wav[$];
  int clr[$];

  // Reference model state. It works from the rise and fall cycle indices.
  bit          tracking;
  int          good;
  int          last_rise;
  int          prev_in;
  logic [31:0] e_edge, e_per, e_high, e_perr, e_herr, e_stuck, e_lock, e_sticky;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    tracking  = 1'b0;
    good      = 0;
    last_rise = 0;
    prev_in   = 0;
    cyc       = 0;
    e_edge = '0; e_per = '0; e_high = '0; e_perr = '0;
    e_herr = '0; e_stuck = '0; e_lock = '0; e_sticky = '0;
  endtask

  // Expected outputs after the clock edge that ends cycle 'cyc'.
  task automatic model_step(input int v, input int c);
    bit rise;
    bit fall;
    bit prev_err;
    prev_err = (e_perr != 0) || (e_herr != 0) || (e_stuck != 0);
    rise = (v != 0) && (prev_in == 0);
    fall = (v == 0) && (prev_in != 0);
    e_edge  = {31'd0, rise};
    e_perr  = '0;
    e_herr  = '0;
    e_stuck = '0;
    if (fall && tracking) begin
      e_high = cyc - last_rise;
      if (cyc - last_rise != EXP_HIGH) begin
        e_herr = 32'd1;
        good   = 0;
      end
    end
    if (rise) begin
      if (tracking) begin
        e_per = cyc - last_rise;
        if (cyc - last_rise != EXP_PERIOD) begin
          e_perr = 32'd1;
          good   = 0;
        end else if (good < LOCK_COUNT) begin
          good++;
        end
      end
      tracking  = 1'b1;
      last_rise = cyc;
    end else if (tracking && (cyc - last_rise == TIMEOUT)) begin
      e_stuck  = 32'd1;
      tracking = 1'b0;
      good     = 0;
    end
    e_lock   = {31'd0, (good == LOCK_COUNT)};
    e_sticky = prev_err ? 32'd1 : ((c != 0) ? 32'd0 : e_sticky);
    prev_in  = v;
    cyc++;
  endtask

  task automatic check_all();
    chk("edge_pulse", {31'd0, edge_pulse}, e_edge);
    chk("period_meas", {24'd0, period_meas}, e_per);
    chk("high_meas", {24'd0, high_meas}, e_high);
    chk("period_err", {31'd0, period_err}, e_perr);
    chk("high_err", {31'd0, high_err}, e_herr);
    chk("stuck_err", {31'd0, stuck_err}, e_stuck);
    chk("locked", {31'd0, locked}, e_lock);
`ifdef CLKMON_STICKY_EN
    chk("err_sticky", {31'd0, err_sticky}, e_sticky);
`endif
  endtask

  // One period: h cycles high then p-h cycles low. err_clr is set at offset clr_at.
  task automatic add_period(input int h, input int p, input int clr_at);
    for (int j = 0; j < p; j++) begin
      wav.push_back((j < h) ? 1 : 0);
      clr.push_back((j == clr_at) ? 1 : 0);
    end
  endtask

  task automatic add_level(input int v, input int n);
    for (int j = 0; j < n; j++) begin
      wav.push_back(v);
      clr.push_back(0);
    end
  endtask

  task automatic run_seq();
    for (int i = 0; i < wav.size(); i++) begin
      div_clk_in = (wav[i] != 0);
`ifdef CLKMON_STICKY_EN
      err_clr = (clr[i] != 0);
`endif
      @(posedge clk);
      #1;
      model_step(wav[i], clr[i]);
      check_all();
    end
    wav.delete();
    clr.delete();
  endtask

  initial begin
    int p;
    int h;
    int r;
    n_pass     = 0;
    n_total    = 0;
    rst_n      = 1'b0;
    div_clk_in = 1'b0;
`ifdef CLKMON_STICKY_EN
    err_clr = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Ideal acquisition and lock, then a stretched period and re-lock.
    add_level(0, 3);
    for (int k = 0; k < 6; k++) add_period(2, 6, -1);
    add_period(2, 7, -1);
    add_period(2, 6, 1);
    for (int k = 0; k < 5; k++) add_period(2, 6, (k == 2) ? 3 : -1);
    // High phase of 3 with the period kept at 6.
    add_period(3, 6, -1);
    for (int k = 0; k < 5; k++) add_period(2, 6, -1);
    // Held low: timeout, then the next rise gives no period check.
    add_level(0, 30);
    for (int k = 0; k < 6; k++) add_period(2, 6, -1);
    // Held high: timeout while high.
    add_period(30, 32, -1);
    for (int k = 0; k < 6; k++) add_period(2, 6, -1);
    // Period exactly at the timeout (the rise wins), then one just beyond it.
    add_period(2, TIMEOUT, -1);
    for (int k = 0; k < 5; k++) add_period(2, 6, -1);
    add_period(2, TIMEOUT + 1, -1);
    for (int k = 0; k < 6; k++) add_period(2, 6, -1);
    run_seq();

    // Randomized waveform with occasional clears.
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        p = EXP_PERIOD;
        h = EXP_HIGH;
      end else if (r < 8) begin
        p = $urandom_range(2, 12);
        h = $urandom_range(1, p - 1);
      end else begin
        p = $urandom_range(20, 28);
        h = $urandom_range(1, 3);
      end
      add_period(h, p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, p - 1) : -1);
    end
    for (int k = 0; k < 6; k++) add_period(2, 6, -1);
    run_seq();

    // Asynchronous reset in the middle of a locked period.
    add_period(2, 6, -1);
    add_period(1, 1, -1);
    run_seq();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    div_clk_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    add_level(0, 3);
    for (int k = 0; k < 7; k++) add_period(2, 6, -1);
    run_seq();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
